ir_fetch: RTL and testbench
===========================

# ir_fetch

Instruction-fetch and instruction-register stage of the multi-cycle MIPS54 datapath. On a fetch command from the control unit, the block issues a word read to instruction memory and waits for the acknowledge. It then latches the returned word into the IR and presents the decoded fields. These fields include the 16-bit immediate and the sign/zero select consumed by the immediate extender.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-state limit before a fetch is aborted. Used only with `IR_FETCH_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: the only clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `fetch_start`, in, 1: one-cycle fetch command from the control unit.
- `pc`, in, 32: fetch address, sampled with `fetch_start`.
- `imem_req`, out, 1: read request, held until acknowledge or abort.
- `imem_addr`, out, 32: registered fetch address, stable while `imem_req` is high.
- `imem_ack`, in, 1: read data valid this cycle.
- `imem_rdata`, in, 32: instruction word, qualified by `imem_ack`.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse; IR has been updated.
- `fault`, out, 1: one-cycle pulse; misaligned PC or timeout. IR is unchanged.
- `ir`, out, 32: instruction register.
- `opcode`, out, 6: `ir[31:26]`.
- `rs`, out, 5: `ir[25:21]`.
- `rt`, out, 5: `ir[20:16]`.
- `rd`, out, 5: `ir[15:11]`.
- `shamt`, out, 5: `ir[10:6]`.
- `funct`, out, 6: `ir[5:0]`.
- `imm16`, out, 16: `ir[15:0]`; feeds the extender data input.
- `ext_sign`, out, 1: extender mode select; 1 = sign-extend, 0 = zero-extend.

## Operation
- FSM states:
  - IDLE: waiting for a command.
  - WAIT: request outstanding.
- IDLE with `fetch_start`=1:
  - If `pc[1:0]`≠0: `fault` pulses next cycle and the FSM stays in IDLE. No request is issued.
  - Otherwise: `imem_addr`←`pc`, `imem_req`←1, go to WAIT.
- WAIT with `imem_ack`=1:
  - `ir`←`imem_rdata`.
  - `ext_sign`←decode of `imem_rdata[31:26]`.
  - `imem_req`←0 and `done`←1 on the same edge, then return to IDLE.
- `fetch_start` is ignored while in WAIT. `imem_ack` is ignored while in IDLE.
- `ext_sign` decode:
  - 0 for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori), 0x0F (lui).
  - 1 for all other opcodes, including branches, loads, stores, addi, addiu, slti and sltiu.
- `ext_sign` is registered together with `ir` so the two never disagree. All field outputs are wire slices of `ir`.
- `done` and `fault` are mutually exclusive and are never high for more than one cycle.

## Timing
- `fetch_start` is sampled at edge E0. `imem_req` is high from E0 through the edge that samples `imem_ack`.
- If `imem_ack` is high in the cycle after E0, the IR updates and `done` rises at E1. This is the minimum latency of one edge.
- Each wait-state cycle adds one cycle of latency.
- A new `fetch_start` is accepted in the same cycle `done` is high, because the FSM is already back in IDLE.
- Reset values:
  - `imem_req`=0, `imem_addr`=0, `busy`=0, `done`=0, `fault`=0.
  - `ir`=0 (NOP), so every field output is 0.
  - `ext_sign`=1.
- Asserting `rst_n` mid-fetch drops `imem_req` immediately, without waiting for a clock edge. A late `imem_ack` after release is ignored.

## Configuration
- `IR_FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the counter equals `TIMEOUT_CYCLES` with `imem_ack`=0, the block drops `imem_req`, pulses `fault`, returns to IDLE, and leaves the IR unchanged.
  - If `imem_ack` arrives in the same cycle as the timeout, the acknowledge wins: the fetch completes normally.
- `IR_FETCH_TIMEOUT_EN` undefined:
  - No counter is built.
  - WAIT holds indefinitely until `imem_ack`.
  - `fault` fires only for a misaligned PC.

## Test plan
- Reset check: after reset, `ir`=0, `ext_sign`=1, `imem_req`=0. Then `fetch_start` with `pc`=0x00400000 and `imem_ack` in the next cycle with data 0x2008FFFF (addi) gives `done` at E1, `imm16`=0xFFFF, `ext_sign`=1, `rt`=8.
- `pc`=0x00400004, three wait states, data 0x3508FFFF (ori): `imem_addr` is stable for 4 cycles, then `done`, `ext_sign`=0, `opcode`=0x0D.
- `pc`=0x00400002: `fault` pulses for one cycle, `imem_req` never rises, and the IR keeps its previous value.
- `fetch_start` pulsed during WAIT has no effect. Back-to-back fetches issued in the `done` cycle both complete, in order.
- `rst_n` low during WAIT: `imem_req` falls asynchronously and all outputs return to reset values. An `imem_ack` after release does not change the IR.
- With `IR_FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack: `fault` fires and the IR is unchanged. With the ack landing exactly on the timeout cycle: `done` fires and there is no `fault`.

Source files
------------

// File: rtl/ir_fetch.sv
// MIPS54 instruction fetch + IR stage: word read from imem, IR latch, field decode.
// Optional wait-state timeout enabled by defining IR_FETCH_TIMEOUT_EN.
module ir_fetch #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        ext_sign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        load_addr;
  logic        load_ir;
  logic        done_nxt;
  logic        fault_nxt;
  logic        timeout;
  logic        sign_nxt;

`ifdef IR_FETCH_TIMEOUT_EN
  logic [7:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (load_addr) begin
      wcnt <= '0;
    end else if (state == S_WAIT) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  assign timeout = (wcnt == 8'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // logical-immediate ops (andi/ori/xori/lui) zero-extend
  always_comb begin
    sign_nxt = 1'b1;
    unique case (1'b1)
      (imem_rdata[31:28] == 4'b0011): sign_nxt = 1'b0;
      default:                        sign_nxt = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    load_ir   = 1'b0;
    done_nxt  = 1'b0;
    fault_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fetch_start) begin
          if (pc[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
          end else begin
            load_addr = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          load_ir   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout) begin
          fault_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      imem_addr <= '0;
      ir        <= '0;
      ext_sign  <= 1'b1;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      fault <= fault_nxt;
      if (load_addr) begin
        imem_addr <= pc;
      end
      if (load_ir) begin
        ir       <= imem_rdata;
        ext_sign <= sign_nxt;
      end
    end
  end

  // request follows the state register so reset drops it at once
  assign imem_req = (state == S_WAIT);
  assign busy     = (state != S_IDLE);

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Randomised bench for ir_fetch against a transaction-level fetch model.
// Define IR_FETCH_TIMEOUT_EN to also exercise the wait-state timeout.
module tb_ir_fetch;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        busy, done, fault;
  logic [31:0] ir;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        ext_sign;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_ir = '0;
  logic        m_sign = 1'b1;

  always #5 clk = ~clk;

  ir_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_start(fetch_start), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .busy(busy), .done(done), .fault(fault),
    .ir(ir), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .ext_sign(ext_sign)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic sign_of(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    return !(op == 'h0C || op == 'h0D || op == 'h0E || op == 'h0F);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag);
    chk({tag, ".ir"}, ir, m_ir);
    chk({tag, ".sign"}, 32'(ext_sign), 32'(m_sign));
    chk({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct}, m_ir);
    chk({tag, ".imm16"}, 32'(imm16), 32'(m_ir[15:0]));
  endtask

  // one fetch; waits = wait-state cycles before ack, -1 = never ack
  task automatic fetch(input logic [31:0] a, input logic [31:0] w,
                       input int waits, input bit noise);
    fetch_start = 1'b1;
    pc = a;
    tick();
    fetch_start = 1'b0;
    if (a[1:0] != 2'b00) begin
      chk("mis.fault", 32'(fault), 1);
      chk("mis.req", 32'(imem_req), 0);
      chk("mis.done", 32'(done), 0);
      chk_ir("mis");
      tick();
      chk("mis.fault1", 32'(fault), 0);
      chk("mis.req1", 32'(imem_req), 0);
      return;
    end
    for (int i = 0; i < ((waits < 0) ? TMO + 1 : waits); i++) begin
      chk("w.req", 32'(imem_req), 1);
      chk("w.addr", imem_addr, a);
      chk("w.busy", 32'(busy), 1);
      chk("w.pulse", 32'({done, fault}), 0);
      if (noise) begin
        fetch_start = 1'($urandom);
        pc = $urandom & 32'hFFFF_FFFC;
      end
      imem_rdata = $urandom;
      tick();
      fetch_start = 1'b0;
    end
    if (waits < 0) begin
      chk("tmo.fault", 32'(fault), 1);
      chk("tmo.done", 32'(done), 0);
      chk("tmo.req", 32'(imem_req), 0);
      chk_ir("tmo");
      return;
    end
    chk("a.req", 32'(imem_req), 1);
    chk("a.addr", imem_addr, a);
    imem_ack = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    m_ir = w;
    m_sign = sign_of(w);
    chk("d.done", 32'(done), 1);
    chk("d.fault", 32'(fault), 0);
    chk("d.req", 32'(imem_req), 0);
    chk("d.busy", 32'(busy), 0);
    chk_ir("d");
  endtask

  initial begin
    #12;
    chk("rst.ir", ir, 0);
    chk("rst.sign", 32'(ext_sign), 1);
    chk("rst.req", 32'(imem_req), 0);
    chk("rst.addr", imem_addr, 0);
    chk("rst.flags", 32'({busy, done, fault}), 0);
    rst_n = 1'b1;
    tick();

    fetch(32'h0040_0000, 32'h2008_FFFF, 0, 1'b0);
    chk("t1.imm", 32'(imm16), 32'hFFFF);
    chk("t1.rt", 32'(rt), 8);
    chk("t1.sign", 32'(ext_sign), 1);
    tick();
    chk("t1.done1", 32'(done), 0);

    fetch(32'h0040_0004, 32'h3508_FFFF, 3, 1'b0);
    chk("t2.sign", 32'(ext_sign), 0);
    chk("t2.op", 32'(opcode), 32'h0D);
    tick();

    fetch(32'h0040_0002, 32'hDEAD_BEEF, 0, 1'b0);

    // ack while idle must be ignored
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk_ir("idleack");
    chk("idleack.done", 32'(done), 0);

    // fetch_start during WAIT, then back-to-back in the done cycle
    fetch(32'h0000_1000, 32'h3C01_ABCD, 3, 1'b1);
    fetch(32'h0000_1004, 32'h8C22_0010, 1, 1'b0);
    fetch(32'h0000_1008, 32'h3022_8000, 0, 1'b0);

    // reset mid-fetch
    fetch_start = 1'b1;
    pc = 32'h0000_2000;
    tick();
    fetch_start = 1'b0;
    tick();
    rst_n = 1'b0;
    m_ir = '0;
    m_sign = 1'b1;
    #1;
    chk("arst.req", 32'(imem_req), 0);
    chk("arst.addr", imem_addr, 0);
    chk("arst.flags", 32'({busy, done, fault}), 0);
    chk_ir("arst");
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    chk_ir("lateack");
    chk("lateack.done", 32'(done), 0);

`ifdef IR_FETCH_TIMEOUT_EN
    fetch(32'h0000_3000, 32'h0, -1, 1'b0);
    tick();
    chk("tmo.fault1", 32'(fault), 0);
    fetch(32'h0000_3004, 32'h3108_00FF, TMO, 1'b0);
    tick();
`endif

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int wmax;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
`ifdef IR_FETCH_TIMEOUT_EN
      wmax = TMO;
`else
      wmax = 6;
`endif
      fetch(a, $urandom, $urandom_range(wmax), 1'($urandom));
      if ($urandom_range(1) != 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
